// File: rtl/apple2_disk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apple2_disk_pkg
//  Description : Shared types and defaults for the NIB track loader: the
//                sequencer state encoding, geometry defaults and the
//                track-to-LBA helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package apple2_disk_pkg;

  // Sequencer states: write-back phase (WB_*) then read phase (RD_*)
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WB_REQ = 3'd1,
    ST_WB_ACK = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_RD_ACK = 3'd4
  } trk_state_t;

  // 512-byte SD sectors per NIB track, and number of valid tracks
  localparam int DEF_SECS_PER_TRACK = 13;
  localparam int DEF_NUM_TRACKS     = 35;

  // First SD sector of a track inside the image
  function automatic logic [31:0] track_base_lba(input logic [5:0] trk, input int spt);
    return 32'(trk) * 32'(spt);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_sector_hs.sv
`default_nettype none
// ============================================================================
//  Module      : sd_sector_hs
//  Description : One-sector request/acknowledge handshake toward the HPS.
//                While armed it raises the request, drops it on the rising
//                edge of ack, and flags the falling edge of ack as sector
//                completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_sector_hs (
  input  logic clk_sys,
  input  logic reset,
  input  logic i_arm,     // sequencer sits in a REQ state
  input  logic i_ack,     // HPS transfer acknowledge
  output logic o_req,     // request toward the HPS
  output logic o_accept,  // ack rose while the request was out
  output logic o_done     // ack fell: sector transfer finished
);

  logic r_req;
  logic r_ack_d;

  // Only an ack edge seen while our request is visible counts, so the request
  // is always high for at least one cycle before it can be withdrawn.
  assign o_accept = r_req && i_ack && !r_ack_d;
  assign o_done   = r_ack_d && !i_ack;
  assign o_req    = r_req;

  // Request register and ack edge history
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_ack_d <= 1'b0;
    end else begin
      r_ack_d <= i_ack;
      if (!i_arm) begin
        r_req <= 1'b0;
      end else if (o_accept) begin
        r_req <= 1'b0;
      end else begin
        r_req <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nib_track_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nib_track_ctrl
//  Description : Keeps the NIB track RAM in step with the drive head. On a
//                track change (or a fresh mount) it writes the current track
//                back to SD if it was modified, then reads the new track,
//                stalling the CPU for the whole sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module nib_track_ctrl
  import apple2_disk_pkg::*;
#(
  parameter int SECS_PER_TRACK = DEF_SECS_PER_TRACK,
  parameter int NUM_TRACKS     = DEF_NUM_TRACKS
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [5:0]  track,
  input  logic        track_wr,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  output logic [3:0]  track_sec,
  output logic        cpu_wait,
  output logic        busy
);

  localparam logic [3:0] c_LAST_SEC = 4'(SECS_PER_TRACK - 1);
  localparam logic [5:0] c_MAX_TRK  = 6'(NUM_TRACKS - 1);
  localparam logic [5:0] c_NO_TRACK = 6'h3F;

  trk_state_t  r_state;
  logic [5:0]  r_cur_track;
  logic [5:0]  r_tgt_track;
  logic        r_dirty;
  logic        r_mount_pend;
  logic [3:0]  r_track_sec;
  logic [31:0] r_sd_lba;
  logic        r_cpu_wait;

  logic [5:0]  w_trk_clamp;
  logic        w_img_present;
  logic        w_cur_valid;
  logic        w_mark_dirty;
  logic        w_dirty_eff;
  logic        w_go;
  logic        w_arm;
  logic        w_last;
  logic        w_req;
  logic        w_accept;
  logic        w_done;

  assign w_trk_clamp   = (int'(track) >= NUM_TRACKS) ? c_MAX_TRK : track;
  assign w_img_present = (img_size != 64'd0);
  // No write-back makes sense before a real track has been loaded
  assign w_cur_valid   = (int'(r_cur_track) < NUM_TRACKS);
  assign w_mark_dirty  = track_wr && !img_readonly && w_img_present && w_cur_valid;
  // A write landing in the same cycle as a step must still be written back
  assign w_dirty_eff   = r_dirty || w_mark_dirty;
  assign w_go          = w_img_present && (r_mount_pend || (w_trk_clamp != r_cur_track));
  assign w_arm         = (r_state == ST_WB_REQ) || (r_state == ST_RD_REQ);
  assign w_last        = (r_track_sec == c_LAST_SEC);

  sd_sector_hs u_hs (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .i_arm    (w_arm),
    .i_ack    (sd_ack),
    .o_req    (w_req),
    .o_accept (w_accept),
    .o_done   (w_done)
  );

  assign sd_rd     = w_req && (r_state == ST_RD_REQ);
  assign sd_wr     = w_req && (r_state == ST_WB_REQ);
  assign sd_lba    = r_sd_lba;
  assign track_sec = r_track_sec;
  assign cpu_wait  = r_cpu_wait;
  assign busy      = (r_state != ST_IDLE);

  // Track sequencer: write-back phase, read phase, mount abort handling
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cur_track  <= c_NO_TRACK;
      r_tgt_track  <= 6'd0;
      r_dirty      <= 1'b0;
      r_mount_pend <= 1'b0;
      r_track_sec  <= 4'd0;
      r_sd_lba     <= 32'd0;
      r_cpu_wait   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_dirty <= w_dirty_eff;
          if (w_go) begin
            r_tgt_track  <= w_trk_clamp;
            r_track_sec  <= 4'd0;
            r_cpu_wait   <= 1'b1;
            r_mount_pend <= 1'b0;
            if (w_dirty_eff) begin
              r_state  <= ST_WB_REQ;
              r_sd_lba <= track_base_lba(r_cur_track, SECS_PER_TRACK);
            end else begin
              r_state  <= ST_RD_REQ;
              r_sd_lba <= track_base_lba(w_trk_clamp, SECS_PER_TRACK);
            end
          end
        end

        ST_WB_REQ: begin
          if (w_accept) r_state <= ST_WB_ACK;
        end

        ST_WB_ACK: begin
          if (w_done) begin
            if (r_mount_pend) begin
              // New image: the old track contents are stale, stop here
              r_state     <= ST_IDLE;
              r_track_sec <= 4'd0;
              r_cpu_wait  <= 1'b0;
            end else if (w_last) begin
              r_dirty     <= 1'b0;
              r_track_sec <= 4'd0;
              r_sd_lba    <= track_base_lba(r_tgt_track, SECS_PER_TRACK);
              r_state     <= ST_RD_REQ;
            end else begin
              r_track_sec <= r_track_sec + 4'd1;
              r_sd_lba    <= r_sd_lba + 32'd1;
              r_state     <= ST_WB_REQ;
            end
          end
        end

        ST_RD_REQ: begin
          if (w_accept) r_state <= ST_RD_ACK;
        end

        ST_RD_ACK: begin
          if (w_done) begin
            if (r_mount_pend) begin
              r_state     <= ST_IDLE;
              r_track_sec <= 4'd0;
              r_cpu_wait  <= 1'b0;
            end else if (w_last) begin
              r_cur_track <= r_tgt_track;
              r_track_sec <= 4'd0;
              r_cpu_wait  <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_track_sec <= r_track_sec + 4'd1;
              r_sd_lba    <= r_sd_lba + 32'd1;
              r_state     <= ST_RD_REQ;
            end
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_cpu_wait <= 1'b0;
        end
      endcase

      // A mount anywhere discards pending modifications and forces a reload
      if (img_mounted) begin
        r_mount_pend <= 1'b1;
        r_dirty      <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nib_track_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nib_track_ctrl
//  Description : Scoreboard bench for nib_track_ctrl. Stimulus pushes the
//                expected SD requests; a monitor pops one per new request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nib_track_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [5:0]  track;
  logic        track_wr;
  logic        img_mounted;
  logic        img_readonly;
  logic [63:0] img_size;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [3:0]  track_sec;
  logic        cpu_wait;
  logic        busy;

  always #5 clk_sys = ~clk_sys;

  nib_track_ctrl dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .track        (track),
    .track_wr     (track_wr),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size     (img_size),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .track_sec    (track_sec),
    .cpu_wait     (cpu_wait),
    .busy         (busy)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] lba;
    logic [3:0]  sec;
  } exp_t;

  exp_t exp_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   n_req   = 0;
  int   gap_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic wr, input int base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(exp_t'{wr: wr, lba: 32'(base + i), sec: 4'(i)});
  endtask

  task automatic wait_quiet();
    int q;
    q = 0;
    for (int k = 0; k < 5000 && q < 4; k++) begin
      @(negedge clk_sys);
      if (busy) q = 0;
      else      q++;
    end
    if (q < 4) begin
      total++;
      bad++;
      $display("FAIL wait_idle_timeout: got busy want idle");
    end
  endtask

  task automatic wait_nreq(input int n);
    for (int k = 0; k < 3000 && n_req < n; k++) @(posedge clk_sys);
    if (n_req < n) begin
      total++;
      bad++;
      $display("FAIL wait_req_timeout: got %0d want %0d", n_req, n);
    end
  endtask

  task automatic pulse_wr();
    track_wr = 1'b1;
    @(negedge clk_sys);
    track_wr = 1'b0;
  endtask

  // HPS model: ack one cycle after a request, hold it for two cycles
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset && (sd_rd || sd_wr) && !sd_ack) begin
        @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat (2) @(negedge clk_sys);
        sd_ack = 1'b0;
      end
    end
  end

  // Monitor: every new request is compared against the next expectation
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset && (sd_rd || sd_wr) && !prev) begin
        n_req++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req: got rd=%0b wr=%0b lba=%0d want none", sd_rd, sd_wr, sd_lba);
        end else begin
          e = exp_q.pop_front();
          check("req{wr,rd,lba,sec,wait}", {sd_wr, sd_rd, sd_lba, track_sec, cpu_wait},
                {e.wr, ~e.wr, e.lba, e.sec, 1'b1});
        end
      end
      prev = sd_rd || sd_wr;
      if (busy && !cpu_wait) gap_cnt++;
    end
  end

  // Directed stimulus
  initial begin
    int seen;
    int base;
    reset        = 1'b1;
    track        = 6'd0;
    track_wr     = 1'b0;
    img_mounted  = 1'b0;
    img_readonly = 1'b0;
    img_size     = 64'd0;
    repeat (3) @(negedge clk_sys);
    check("rst_sd_rd",    sd_rd, 0);
    check("rst_sd_wr",    sd_wr, 0);
    check("rst_cpu_wait", cpu_wait, 0);
    check("rst_busy",     busy, 0);
    check("rst_sec",      track_sec, 0);
    check("rst_lba",      sd_lba, 0);
    check("rst_cur",      dut.r_cur_track, 6'h3F);
    check("rst_dirty",    dut.r_dirty, 0);
    reset = 1'b0;

    // No image: a track change must stay silent
    seen  = 0;
    track = 6'd3;
    pulse_wr();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr || cpu_wait || busy) seen++;
    end
    check("nosize_quiet", seen, 0);
    check("nosize_dirty", dut.r_dirty, 0);

    // Insert image with head on track 0: first load
    track = 6'd0;
    push_seq(1'b0, 0, 13);
    img_size = 64'd232960;
    wait_quiet();
    check("load0_drain", exp_q.size(), 0);
    check("load0_cur", dut.r_cur_track, 0);

    // Clean step 0 -> 5
    gap_cnt = 0;
    push_seq(1'b0, 65, 13);
    track = 6'd5;
    wait_quiet();
    check("step5_drain", exp_q.size(), 0);
    check("step5_cur", dut.r_cur_track, 5);
    check("step5_wait_held", gap_cnt, 0);

    // Dirty step 5 -> 6: write back 65..77 then read 78..90
    pulse_wr();
    check("dirty_set", dut.r_dirty, 1);
    push_seq(1'b1, 65, 13);
    push_seq(1'b0, 78, 13);
    track = 6'd6;
    wait_quiet();
    check("wb6_drain", exp_q.size(), 0);
    check("wb6_dirty", dut.r_dirty, 0);
    check("wb6_cur", dut.r_cur_track, 6);

    // Back to 5, then 5 -> 6 with a step to 7 during sector 3
    push_seq(1'b0, 65, 13);
    track = 6'd5;
    wait_quiet();
    base = n_req;
    push_seq(1'b0, 78, 13);
    push_seq(1'b0, 91, 13);
    track = 6'd6;
    wait_nreq(base + 4);
    @(negedge clk_sys);
    track = 6'd7;
    wait_quiet();
    check("chg7_drain", exp_q.size(), 0);
    check("chg7_cur", dut.r_cur_track, 7);

    // Read-only image: writes never mark the track dirty
    img_readonly = 1'b1;
    pulse_wr();
    check("ro_dirty", dut.r_dirty, 0);
    push_seq(1'b0, 65, 13);
    track = 6'd5;
    wait_quiet();
    img_readonly = 1'b0;
    check("ro_drain", exp_q.size(), 0);
    check("ro_cur", dut.r_cur_track, 5);

    // Mount during sector 4 of a write-back: finish it, then reload track 6
    pulse_wr();
    push_seq(1'b1, 65, 5);
    push_seq(1'b0, 78, 13);
    base  = n_req;
    track = 6'd6;
    wait_nreq(base + 5);
    @(negedge clk_sys);
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    wait_quiet();
    check("mnt_drain", exp_q.size(), 0);
    check("mnt_dirty", dut.r_dirty, 0);
    check("mnt_cur", dut.r_cur_track, 6);

    // Out-of-range request clamps to the last track (34 -> LBA 442)
    push_seq(1'b0, 442, 13);
    track = 6'd40;
    wait_quiet();
    check("clamp_drain", exp_q.size(), 0);
    check("clamp_cur", dut.r_cur_track, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nib_track_ctrl.md
NIB_TRACK_CTRL -- requirements
Module: nib_track_ctrl

Interface
REQ-001 SHALL have parameter SECS_PER_TRACK, default 13, meaning 512-byte SD sectors per NIB track.
REQ-002 SHALL have parameter NUM_TRACKS, default 35, meaning valid track count; requests at or above it are clamped to NUM_TRACKS-1.
REQ-003 SHALL have port clk_sys, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port track, input, 6, meaning the head track requested by the drive.
REQ-006 SHALL have port track_wr, input, 1, meaning a one-cycle pulse when the drive wrote to track RAM.
REQ-007 SHALL have ports img_mounted (in, 1, mount pulse), img_readonly (in, 1) and img_size (in, 64).
REQ-008 SHALL have port sd_lba, output, 32, meaning the sector address.
REQ-009 SHALL have ports sd_rd and sd_wr (out, 1, requests) and sd_ack (in, 1, HPS transfer acknowledge).
REQ-010 SHALL have port track_sec, output, 4, meaning the sector index for the upper track-RAM address bits.
REQ-011 SHALL have ports cpu_wait (out, 1, stall CPU) and busy (out, 1, sequencer not IDLE).

Function
REQ-012 SHALL implement states IDLE, WB_REQ, WB_ACK, RD_REQ, RD_ACK.
REQ-013 SHALL set the dirty flag on track_wr in IDLE when img_readonly=0 and img_size!=0, and SHALL clear it after the last write-back sector.
REQ-014 SHALL, in IDLE, start a sequence when the clamped track differs from cur_track, or one cycle after a mount pulse; no sequence starts if img_size=0.
REQ-015 SHALL go from IDLE to WB_REQ when dirty=1, else to RD_REQ; the entry cycle latches tgt_track and sets track_sec=0 and cpu_wait=1.
REQ-016 SHALL compute base LBA = track*SECS_PER_TRACK (track = cur_track for write-back, tgt_track for read), and sd_lba = base + track_sec.
REQ-017 SHALL, in WB_REQ/RD_REQ, hold sd_wr/sd_rd high until sd_ack rises, then drop the request and move to WB_ACK/RD_ACK.
REQ-018 SHALL, in the ACK states, increment track_sec when sd_ack falls; if track_sec was SECS_PER_TRACK-1 the phase ends, otherwise return to the REQ state.
REQ-019 SHALL, at the end of write-back, clear dirty, reset track_sec to 0 and enter RD_REQ.
REQ-020 SHALL, at the end of a read, set cur_track=tgt_track and go to IDLE; cpu_wait falls in the same cycle.
REQ-021 SHALL never assert sd_rd and sd_wr together, and SHALL keep each request high for at least 1 cycle.
REQ-022 SHALL, when track changes during a sequence, finish the sequence for the latched target; IDLE then re-evaluates and starts a new read with no idle gap beyond one cycle.
REQ-023 SHALL, on a mount pulse during a sequence, discard dirty, set the pending-mount flag, finish the in-flight sector handshake, and then go to IDLE, which restarts a read of the current track.
REQ-024 SHALL ignore track_wr outside IDLE.
REQ-025 SHALL make busy equal to (state != IDLE).

Reset
REQ-026 SHALL, on reset, set state=IDLE, sd_rd=0, sd_wr=0, cpu_wait=0, track_sec=0, sd_lba=0 and dirty=0.
REQ-027 SHALL, on reset, set cur_track=6'h3F so that the first valid track forces a load.
REQ-028 SHALL let reset mid-transfer abandon the sequence immediately without waiting for sd_ack.

Structure
REQ-029 SHALL take the state enum and SECS_PER_TRACK/NUM_TRACKS defaults from a shared package apple2_disk_pkg.
REQ-030 SHALL contain one sub-module, sd_sector_hs, which runs the per-sector request/ack edge handshake and is used by both phases.

Verification
REQ-031 SHALL verify: img_size=232960, track 0->5 clean -> 13 reads with LBA 65..77, cpu_wait high throughout, cur_track=5.
REQ-032 SHALL verify: track 5, one track_wr, step to 6 -> 13 writes with LBA 65..77, then 13 reads with LBA 78..90, dirty=0 at end.
REQ-033 SHALL verify: img_readonly=1, track_wr, step -> no sd_wr, only reads.
REQ-034 SHALL verify: track 5->6, with track set to 7 during sector 3 -> read of 78..90 completes, then 91..103 follows, final cur_track=7.
REQ-035 SHALL verify: img_mounted pulse during sector 4 of a dirty write-back -> in-flight ack completes, no further sd_wr, read of the current track follows.
REQ-036 SHALL verify: img_size=0 with a track change -> sd_rd, sd_wr and cpu_wait stay 0.
